// File: rtl/hand_scorer_if.sv
// Card handshake between the dealer stage (master) and a hand scorer (slave).
interface hand_scorer_if;
  logic [3:0] card_in;
  logic       card_valid;
  logic       card_ready;

  modport master (output card_in, output card_valid, input card_ready);
  modport slave  (input card_in, input card_valid, output card_ready);
endinterface

// File: rtl/hand_scorer.sv
// Scores one blackjack hand: best total, soft ace, bust, natural and completion,
// one card per handshake on the cards interface.
module hand_scorer #(
  parameter int MAX_CARDS = 11
) (
  input  logic               clk,
  input  logic               reset,
  hand_scorer_if.slave       cards,
  input  logic               new_hand_i,
  input  logic               stand_i,
  output logic [4:0]         total_o,
  output logic               soft_o,
  output logic [3:0]         card_count_o,
  output logic               bust_o,
  output logic               blackjack_o,
  output logic               done_o,
  output logic               bad_card_o
);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_STAND, S_BUST} state_e;

  localparam logic [3:0] MAX_CNT = 4'(MAX_CARDS);

  state_e     state_q, state_d;
  logic [4:0] hard_sum_q, hard_sum_d;
  logic       ace_seen_q, ace_seen_d;
  logic [3:0] card_count_q, card_count_d;
  logic       bust_q, bust_d;
  logic       blackjack_q, blackjack_d;
  logic       soft_q, soft_d;
  logic [4:0] total_q, total_d;
  logic       bad_card_q, bad_card_d;
  logic       done_q, done_d;

  logic [4:0] card_val;
  logic       card_ok, accept, score;
  logic [4:0] sum_nxt, total_nxt;
  logic       ace_nxt, soft_nxt;
  logic [3:0] count_nxt;

  // Zero marks an invalid code; face cards score 10.
  function automatic logic [4:0] card_value(input logic [3:0] code);
    logic [4:0] v;
    if (code >= 4'd1 && code <= 4'd10)       v = {1'b0, code};
    else if (code >= 4'd11 && code <= 4'd13) v = 5'd10;
    else                                     v = 5'd0;
    return v;
  endfunction

  always_comb begin
    card_val  = card_value(cards.card_in);
    card_ok   = (card_val != 5'd0);
    accept    = cards.card_valid & cards.card_ready;
    score     = accept & card_ok;
    sum_nxt   = hard_sum_q + card_val;
    ace_nxt   = ace_seen_q | (cards.card_in == 4'd1);
    soft_nxt  = ace_nxt & (sum_nxt <= 5'd11);
    total_nxt = soft_nxt ? sum_nxt + 5'd10 : sum_nxt;
    count_nxt = card_count_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (new_hand_i) begin
      state_d = S_COLLECT;
    end else if (state_q == S_COLLECT) begin
      // The card in the same cycle as stand is scored first, so it can still bust.
      if (score && sum_nxt > 5'd21)        state_d = S_BUST;
      else if (score && total_nxt == 5'd21) state_d = S_STAND;
      else if (stand_i)                     state_d = S_STAND;
    end
  end

  always_comb begin
    cards.card_ready = (state_q == S_COLLECT) && (card_count_q < MAX_CNT);
  end

  always_comb begin
    hard_sum_d   = hard_sum_q;
    ace_seen_d   = ace_seen_q;
    card_count_d = card_count_q;
    bust_d       = bust_q;
    blackjack_d  = blackjack_q;
    soft_d       = soft_q;
    total_d      = total_q;
    bad_card_d   = 1'b0;
    if (new_hand_i) begin
      hard_sum_d   = 5'd0;
      ace_seen_d   = 1'b0;
      card_count_d = 4'd0;
      bust_d       = 1'b0;
      blackjack_d  = 1'b0;
      soft_d       = 1'b0;
      total_d      = 5'd0;
    end else if (score) begin
      hard_sum_d   = sum_nxt;
      ace_seen_d   = ace_nxt;
      card_count_d = count_nxt;
      soft_d       = soft_nxt;
      total_d      = total_nxt;
      bust_d       = (sum_nxt > 5'd21);
      blackjack_d  = (count_nxt == 4'd2) && (total_nxt == 5'd21);
    end else if (accept) begin
      bad_card_d   = 1'b1;
    end
    done_d = (state_d == S_STAND) || (state_d == S_BUST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hard_sum_q   <= 5'd0;
      ace_seen_q   <= 1'b0;
      card_count_q <= 4'd0;
      bust_q       <= 1'b0;
      blackjack_q  <= 1'b0;
      soft_q       <= 1'b0;
      total_q      <= 5'd0;
      bad_card_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      hard_sum_q   <= hard_sum_d;
      ace_seen_q   <= ace_seen_d;
      card_count_q <= card_count_d;
      bust_q       <= bust_d;
      blackjack_q  <= blackjack_d;
      soft_q       <= soft_d;
      total_q      <= total_d;
      bad_card_q   <= bad_card_d;
      done_q       <= done_d;
    end
  end

  assign total_o      = total_q;
  assign soft_o       = soft_q;
  assign card_count_o = card_count_q;
  assign bust_o       = bust_q;
  assign blackjack_o  = blackjack_q;
  assign done_o       = done_q;
  assign bad_card_o   = bad_card_q;

endmodule

// File: tb/tb_hand_scorer.sv
// Bench for hand_scorer: directed hands plus random play against a card-list model.
module tb_hand_scorer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       new_hand_a, stand_a, new_hand_b, stand_b;
  logic [4:0] total_a, total_b;
  logic       soft_a, soft_b, bust_a, bust_b, bj_a, bj_b, done_a, done_b, bad_a, bad_b;
  logic [3:0] count_a, count_b;

  hand_scorer_if ifa ();
  hand_scorer_if ifb ();

  hand_scorer #(.MAX_CARDS(11)) dut_a (
    .clk(clk), .reset(reset), .cards(ifa), .new_hand_i(new_hand_a), .stand_i(stand_a),
    .total_o(total_a), .soft_o(soft_a), .card_count_o(count_a), .bust_o(bust_a),
    .blackjack_o(bj_a), .done_o(done_a), .bad_card_o(bad_a));

  hand_scorer #(.MAX_CARDS(3)) dut_b (
    .clk(clk), .reset(reset), .cards(ifb), .new_hand_i(new_hand_b), .stand_i(stand_b),
    .total_o(total_b), .soft_o(soft_b), .card_count_o(count_b), .bust_o(bust_b),
    .blackjack_o(bj_b), .done_o(done_b), .bad_card_o(bad_b));

  int checks = 0;
  int failures = 0;

  // Reference hand: list of accepted card values; state 0 idle, 1 collect, 2 stand, 3 bust.
  int m_vals[$];
  bit m_ace, m_bust, m_bj, m_bad;
  int m_st;

  function automatic int cval(input int c);
    if (c == 1) return 1;
    if (c >= 2 && c <= 10) return c;
    if (c >= 11 && c <= 13) return 10;
    return 0;
  endfunction

  function automatic int m_hard();
    int s = 0;
    foreach (m_vals[i]) s += m_vals[i];
    return s;
  endfunction

  function automatic bit m_soft();
    return m_ace && (m_hard() <= 11);
  endfunction

  function automatic int m_total();
    return m_soft() ? m_hard() + 10 : m_hard();
  endfunction

  function automatic bit m_ready();
    return (m_st == 1) && (m_vals.size() < 11);
  endfunction

  task automatic m_clear();
    m_vals.delete();
    m_ace = 0; m_bust = 0; m_bj = 0; m_bad = 0;
  endtask

  task automatic model_step(input bit rs, input bit nh, input bit v, input int c, input bit st);
    bit decided = 0;
    if (rs) begin
      m_clear(); m_st = 0;
    end else if (nh) begin
      m_clear(); m_st = 1;
    end else begin
      m_bad = 0;
      if (v && m_ready()) begin
        if (cval(c) == 0) begin
          m_bad = 1;
        end else begin
          m_vals.push_back(cval(c));
          if (c == 1) m_ace = 1;
          if (m_hard() > 21) begin
            m_bust = 1; m_st = 3; decided = 1;
          end else if (m_total() == 21) begin
            m_bj = (m_vals.size() == 2); m_st = 2; decided = 1;
          end
        end
      end
      if (!decided && st && m_st == 1) m_st = 2;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_a(input string tag);
    chk({tag, ".total"}, 32'(total_a), m_total());
    chk({tag, ".soft"}, 32'(soft_a), 32'(m_soft()));
    chk({tag, ".count"}, 32'(count_a), m_vals.size());
    chk({tag, ".bust"}, 32'(bust_a), 32'(m_bust));
    chk({tag, ".blackjack"}, 32'(bj_a), 32'(m_bj));
    chk({tag, ".done"}, 32'(done_a), 32'(m_st >= 2));
    chk({tag, ".bad_card"}, 32'(bad_a), 32'(m_bad));
    chk({tag, ".ready"}, 32'(ifa.card_ready), 32'(m_ready()));
  endtask

  task automatic cyc(input string tag, input bit rs, input bit nh, input bit v,
                     input int c, input bit st);
    reset = rs; new_hand_a = nh; ifa.card_valid = v; ifa.card_in = 4'(c); stand_a = st;
    model_step(rs, nh, v, c, st);
    @(posedge clk); #1;
    reset = 0; new_hand_a = 0; ifa.card_valid = 0; stand_a = 0;
    check_a(tag);
  endtask

  task automatic card(input string tag, input int c);
    cyc(tag, 0, 0, 1, c, 0);
  endtask

  task automatic cyc_b(input bit nh, input bit v, input int c, input bit st);
    new_hand_b = nh; ifb.card_valid = v; ifb.card_in = 4'(c); stand_b = st;
    @(posedge clk); #1;
    new_hand_b = 0; ifb.card_valid = 0; stand_b = 0;
  endtask

  initial begin
    int cap[11] = '{1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3};
    reset = 1; new_hand_a = 0; stand_a = 0; new_hand_b = 0; stand_b = 0;
    ifa.card_valid = 0; ifa.card_in = 0; ifb.card_valid = 0; ifb.card_in = 0;
    m_clear(); m_st = 0;

    cyc("reset", 1, 0, 0, 0, 0);
    chk("reset_b.total", 32'(total_b), 0);
    chk("reset_b.ready", 32'(ifb.card_ready), 0);
    card("idle_card", 7);

    // Natural blackjack
    cyc("bj.new", 0, 1, 0, 0, 0);
    card("bj.ace", 1);
    chk("bj.ace_total", 32'(total_a), 11);
    card("bj.king", 13);
    chk("bj.natural", 32'(bj_a), 1);
    chk("bj.total21", 32'(total_a), 21);
    cyc("bj.hold", 0, 0, 1, 5, 1);

    // Soft to hard
    cyc("soft.new", 0, 1, 0, 0, 0);
    card("soft.c1", 1);
    card("soft.c6", 6);
    chk("soft.t17", 32'(total_a), 17);
    card("soft.c9", 9);
    chk("soft.t16", 32'(total_a), 16);
    chk("soft.hard", 32'(soft_a), 0);
    cyc("soft.stand", 0, 0, 0, 0, 1);

    // Bust and a card after bust
    cyc("bust.new", 0, 1, 0, 0, 0);
    card("bust.c10", 10);
    card("bust.c6", 6);
    card("bust.cq", 12);
    chk("bust.t26", 32'(total_a), 26);
    card("bust.after", 4);
    chk("bust.count3", 32'(count_a), 3);

    // Invalid code and new_hand priority
    cyc("bad.new", 0, 1, 0, 0, 0);
    card("bad.c0", 0);
    chk("bad.pulse", 32'(bad_a), 1);
    cyc("bad.idle", 0, 0, 0, 0, 0);
    card("bad.c15", 15);
    card("bad.c3", 3);
    cyc("prio", 0, 1, 1, 5, 1);
    chk("prio.count0", 32'(count_a), 0);

    // Stand and busting card together
    card("sb.c10", 10);
    card("sb.c9", 9);
    cyc("sb.both", 0, 0, 1, 5, 1);
    cyc("sb.new", 0, 1, 0, 0, 0);
    card("sb2.c4", 4);
    cyc("sb2.both", 0, 0, 1, 2, 1);

    // Capacity with 11 cards
    cyc("cap.new", 0, 1, 0, 0, 0);
    foreach (cap[i]) card("cap.card", cap[i]);
    chk("cap.t21", 32'(total_a), 21);
    chk("cap.nobj", 32'(bj_a), 0);

    // Reset mid-hand
    cyc("rst.new", 0, 1, 0, 0, 0);
    card("rst.c9", 9);
    card("rst.c5", 5);
    cyc("rst.pulse", 1, 0, 1, 3, 0);
    card("rst.ignored", 3);

    // Three-card cap instance
    cyc_b(1, 0, 0, 0);
    cyc_b(0, 1, 2, 0);
    cyc_b(0, 1, 2, 0);
    cyc_b(0, 1, 2, 0);
    chk("cap3.ready", 32'(ifb.card_ready), 0);
    chk("cap3.total", 32'(total_b), 6);
    chk("cap3.notdone", 32'(done_b), 0);
    cyc_b(0, 1, 2, 0);
    chk("cap3.count", 32'(count_b), 3);
    cyc_b(0, 0, 0, 1);
    chk("cap3.done", 32'(done_b), 1);

    // Random play
    for (int n = 0; n < 3000; n++) begin
      int r, c;
      bit nh, rs, st, v;
      r  = $urandom_range(0, 99);
      nh = (r < 4);
      rs = (r == 99);
      st = ($urandom_range(0, 19) == 0);
      v  = ($urandom_range(0, 2) != 0);
      c  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 3);
      cyc("rand", rs, nh, v, c, st);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
